fir_input_stage: RTL and testbench

- Upstream front-end of the FIR filter datapath inside tt_um_fit_filter2.
- Captures host bytes from the dedicated input pins using a strobe on a bidirectional pin, which is asynchronous to clk.
- Routes each byte either into a small sample FIFO feeding the FIR core through a valid/ready handshake, or into the core's coefficient register file as auto-addressed writes.

---
 rtl/fir_input_stage.sv | 189 ++++++++++++++++++
 tb/tb_fir_input_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_input_stage.sv
`default_nettype none
// ============================================================================
// Module   : fir_input_stage
// Purpose  : Host input front-end for the FIR datapath. Captures bytes from
//            the dedicated input pins on an asynchronous strobe and steers
//            each one either into a first-word-fall-through sample FIFO or
//            into the coefficient register file as an auto-addressed write.
// Options  : FIR_IN_SIGNED_EN - when defined, sample bytes are converted from
//            offset binary to two's complement (bit 7 inverted) on push.
//            The coefficient path is never converted.
// Ports    : clk, rst_n (async, active low), ena (design enable)
//            din         host data byte, sampled on the write event cycle
//            strobe_pin  host write strobe, asynchronous to clk
//            mode_pin    0 = sample write, 1 = coefficient write, async
//            samp_data / samp_valid / samp_ready  FIFO head handshake
//            coef_data / coef_addr / coef_we      coefficient write port
//            fifo_level  FIFO occupancy 0..DEPTH
//            overflow    sticky: a sample was dropped on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module fir_input_stage #(
   parameter int DEPTH = 4,
   parameter int NTAPS = 8,
   parameter int AW    = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   input  logic [7:0]               din,
   input  logic                     strobe_pin,
   input  logic                     mode_pin,
   output logic [7:0]               samp_data,
   output logic                     samp_valid,
   input  logic                     samp_ready,
   output logic [7:0]               coef_data,
   output logic [AW-1:0]            coef_addr,
   output logic                     coef_we,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   // Synchronizers: [0],[1] form the 2-flop synchronizer, [2] is the
   // history flop used for edge detection.
   logic [2:0]    strb_q;
   logic [2:0]    mode_q;

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [7:0]    samp_data_q, samp_data_d;
   logic          ovf_q, ovf_d;

   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] ptr_base;
   logic [7:0]    coef_data_q, coef_data_d;
   logic [AW-1:0] coef_addr_q, coef_addr_d;
   logic          coef_we_q, coef_we_d;

   logic          w_event;
   logic          w_mode;
   logic          w_mode_rise;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push_req;
   logic          w_push;
   logic          w_drop;
   logic          w_coef_ev;
   logic          w_head_new;
   logic [7:0]    w_samp_in;

`ifdef FIR_IN_SIGNED_EN
   assign w_samp_in = {~din[7], din[6:0]};
`else
   assign w_samp_in = din;
`endif

   assign w_event     = ena & strb_q[1] & ~strb_q[2];
   assign w_mode      = mode_q[1];
   // Entering coefficient mode restarts the address sequence; gated by ena
   // so the pointer holds while the block is disabled.
   assign w_mode_rise = ena & mode_q[1] & ~mode_q[2];

   assign w_full      = (level_q == LW'(DEPTH));
   assign w_empty     = (level_q == '0);
   assign w_pop       = ~w_empty & samp_ready;
   assign w_push_req  = w_event & ~w_mode;
   // At full a push is accepted only if the head leaves in the same cycle.
   assign w_push      = w_push_req & (~w_full | w_pop);
   assign w_drop      = w_push_req & w_full & ~w_pop;
   assign w_coef_ev   = w_event & w_mode;

   // The pushed byte becomes the new head when nothing else remains after
   // this cycle's pop.
   assign w_head_new  = w_push & ((level_q - LW'(w_pop)) == '0);

   always_comb begin
      level_d     = level_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      samp_data_d = samp_data_q;
      ovf_d       = ovf_q | w_drop;

      if (w_push && !w_pop) begin
         level_d = level_q + LW'(1);
      end else if (!w_push && w_pop) begin
         level_d = level_q - LW'(1);
      end
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      // samp_data is a registered copy of the next head; when the FIFO
      // drains it simply keeps the last value shown.
      if (level_d != '0) begin
         if (w_head_new) begin
            samp_data_d = w_samp_in;
         end else begin
            samp_data_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_comb begin
      ptr_base    = w_mode_rise ? '0 : ptr_q;
      ptr_d       = ptr_base;
      coef_data_d = coef_data_q;
      coef_addr_d = coef_addr_q;
      coef_we_d   = 1'b0;
      if (w_coef_ev) begin
         coef_we_d   = 1'b1;
         coef_data_d = din;
         coef_addr_d = ptr_base;
         ptr_d       = (ptr_base == AW'(NTAPS - 1)) ? '0 : ptr_base + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strb_q      <= '0;
         mode_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         samp_data_q <= '0;
         ovf_q       <= 1'b0;
         ptr_q       <= '0;
         coef_data_q <= '0;
         coef_addr_q <= '0;
         coef_we_q   <= 1'b0;
      end else begin
         strb_q      <= {strb_q[1:0], strobe_pin};
         mode_q      <= {mode_q[1:0], mode_pin};
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         samp_data_q <= samp_data_d;
         ovf_q       <= ovf_d;
         ptr_q       <= ptr_d;
         coef_data_q <= coef_data_d;
         coef_addr_q <= coef_addr_d;
         coef_we_q   <= coef_we_d;
      end
   end

   // Storage needs no reset: occupancy and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= w_samp_in;
      end
   end

   assign samp_data  = samp_data_q;
   assign samp_valid = ~w_empty;
   assign fifo_level = level_q;
   assign overflow   = ovf_q;
   assign coef_data  = coef_data_q;
   assign coef_addr  = coef_addr_q;
   assign coef_we    = coef_we_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_input_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_input_stage
// Purpose  : Self-checking bench for fir_input_stage. Stimulus tasks push
//            expected samples / coefficient writes into queues; a monitor
//            pops and compares whenever the DUT pops or writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_input_stage;

   localparam int DEPTH = 4;
   localparam int NTAPS = 8;
   localparam int AW    = 3;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b1;
   logic          ena        = 1'b0;
   logic [7:0]    din        = '0;
   logic          strobe_pin = 1'b0;
   logic          mode_pin   = 1'b0;
   logic          samp_ready = 1'b0;
   wire  [7:0]    samp_data;
   wire           samp_valid;
   wire  [7:0]    coef_data;
   wire  [AW-1:0] coef_addr;
   wire           coef_we;
   wire  [LW-1:0] fifo_level;
   wire           overflow;

   int checks = 0;
   int errors = 0;

   logic [7:0]    exp_q[$];      // model FIFO contents, head first
   logic [AW+7:0] coef_q[$];     // expected {addr, data} writes
   int            mptr = 0;      // model coefficient pointer
   bit            movf = 1'b0;   // model overflow flag
   bit            rnd_ready = 1'b0;

   fir_input_stage #(.DEPTH(DEPTH), .NTAPS(NTAPS), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .din        (din),
      .strobe_pin (strobe_pin),
      .mode_pin   (mode_pin),
      .samp_data  (samp_data),
      .samp_valid (samp_valid),
      .samp_ready (samp_ready),
      .coef_data  (coef_data),
      .coef_addr  (coef_addr),
      .coef_we    (coef_we),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] conv(input logic [7:0] b);
`ifdef FIR_IN_SIGNED_EN
      return b ^ 8'h80;
`else
      return b;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: compare on every DUT pop and every coefficient write.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (samp_valid === 1'b1 && samp_ready === 1'b1) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pop actual=%0h required=none", samp_data);
               end else begin
                  chk("pop_data", {24'h0, samp_data}, {24'h0, exp_q.pop_front()});
               end
            end
            if (coef_we === 1'b1) begin
               if (coef_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_coef_we actual=%0h/%0h required=none", coef_addr, coef_data);
               end else begin
                  chk("coef_write", {21'h0, coef_addr, coef_data}, {21'h0, coef_q.pop_front()});
               end
            end
         end
      end
   end

   // Random backpressure for the randomized sample phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) samp_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Drive one strobe pulse (4 cycles high, 4 low). Optionally raise
   // samp_ready for exactly the write-event cycle; reports the cycle at
   // which samp_valid was first seen high.
   task automatic strobe(input logic [7:0] b, input bit pop_ev, output int lat);
      lat = 0;
      @(posedge clk);
      #1;
      din = b;
      strobe_pin = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         if (lat == 0 && samp_valid === 1'b1) lat = k;
         if (pop_ev && k == 2) samp_ready = 1'b1;
         if (pop_ev && k == 3) samp_ready = 1'b0;
      end
      strobe_pin = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic push_samp(input logic [7:0] b, input bit pop_ev);
      int lat;
      if (exp_q.size() == DEPTH && !pop_ev) movf = 1'b1;
      else exp_q.push_back(conv(b));
      strobe(b, pop_ev, lat);
   endtask

   task automatic push_coef(input logic [7:0] b);
      int lat;
      coef_q.push_back({mptr[AW-1:0], b});
      mptr = (mptr + 1) % NTAPS;
      strobe(b, 1'b0, lat);
   endtask

   task automatic set_mode(input bit m);
      if (m && !mode_pin) mptr = 0;
      @(posedge clk);
      #1;
      mode_pin = m;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      @(posedge clk);
      #1;
      samp_ready = 1'b1;
      repeat (DEPTH + 2) @(posedge clk);
      #1;
      samp_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'h0, samp_valid}, 0);
      chk("rst_level", {29'h0, fifo_level}, 0);
      chk("rst_ovf", {31'h0, overflow}, 0);
      chk("rst_addr", {29'h0, coef_addr}, 0);
      chk("rst_we", {31'h0, coef_we}, 0);
      exp_q.delete();
      coef_q.delete();
      movf = 1'b0;
      mptr = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      logic [7:0] r;

      // Reset state
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", {31'h0, samp_valid}, 0);
      chk("reset_data", {24'h0, samp_data}, 0);
      chk("reset_level", {29'h0, fifo_level}, 0);
      chk("reset_ovf", {31'h0, overflow}, 0);
      chk("reset_we", {31'h0, coef_we}, 0);
      chk("reset_addr", {29'h0, coef_addr}, 0);
      rst_n = 1'b1;
      ena = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single sample and latency
      exp_q.push_back(conv(8'h5A));
      strobe(8'h5A, 1'b0, lat);
      chk("t1_latency_ok", {31'h0, (lat >= 1 && lat <= 4)}, 1);
      chk("t1_valid", {31'h0, samp_valid}, 1);
      chk("t1_data", {24'h0, samp_data}, {24'h0, conv(8'h5A)});
      chk("t1_level", {29'h0, fifo_level}, 1);

      // Fill and overflow
      do_reset();
      for (int i = 1; i <= 5; i++) push_samp(8'(i), 1'b0);
      chk("t2_level", {29'h0, fifo_level}, DEPTH);
      chk("t2_ovf", {31'h0, overflow}, {31'h0, movf});
      chk("t2_head", {24'h0, samp_data}, {24'h0, conv(8'h01)});
      drain();
      chk("t2_empty", {31'h0, samp_valid}, 0);
      chk("t2_hold", {24'h0, samp_data}, {24'h0, conv(8'h04)});
      chk("t2_ovf_sticky", {31'h0, overflow}, 1);
      chk("t2_sb_empty", exp_q.size(), 0);

      // Simultaneous push and pop at full
      do_reset();
      for (int i = 0; i < 4; i++) push_samp(8'h10 + 8'(i), 1'b0);
      chk("t3_full", {29'h0, fifo_level}, DEPTH);
      push_samp(8'h14, 1'b1);
      chk("t3_level", {29'h0, fifo_level}, DEPTH);
      chk("t3_ovf", {31'h0, overflow}, 0);
      chk("t3_head", {24'h0, samp_data}, {24'h0, conv(8'h11)});
      drain();
      chk("t3_sb_empty", exp_q.size(), 0);

      // Coefficient load with wrap
      set_mode(1'b1);
      for (int i = 0; i < 9; i++) push_coef(8'hA0 + 8'(i));
      chk("t4_coef_done", coef_q.size(), 0);
      chk("t4_level", {29'h0, fifo_level}, 0);
      chk("t4_last_addr", {29'h0, coef_addr}, 0);
      for (int i = 0; i < 5; i++) push_coef(8'($urandom));
      set_mode(1'b0);
      set_mode(1'b1);
      for (int i = 0; i < 3; i++) push_coef(8'($urandom));
      chk("t4_restart_addr", {29'h0, coef_addr}, 2);
      chk("t4_coef_done2", coef_q.size(), 0);
      set_mode(1'b0);

      // ena gating
      ena = 1'b0;
      strobe(8'h77, 1'b0, lat);
      chk("t5_no_push", {29'h0, fifo_level}, 0);
      set_mode(1'b1);
      strobe(8'h55, 1'b0, lat);
      set_mode(1'b0);
      ena = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      push_samp(8'h77, 1'b0);
      chk("t5_push", {29'h0, fifo_level}, 1);
      chk("t5_data", {24'h0, samp_data}, {24'h0, conv(8'h77)});
      drain();

      // Randomized samples under random backpressure
      rnd_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (exp_q.size() < DEPTH) begin
            r = 8'($urandom);
            push_samp(r, 1'b0);
         end else begin
            repeat (2) @(posedge clk);
            #1;
         end
      end
      rnd_ready = 1'b0;
      @(posedge clk);
      #1;
      samp_ready = 1'b0;
      drain();
      chk("rnd_sb_empty", exp_q.size(), 0);
      chk("rnd_ovf", {31'h0, overflow}, {31'h0, movf});

      // Reset mid-stream, then one more sample
      for (int i = 0; i < 3; i++) push_samp(8'(i + 8'h30), 1'b0);
      chk("t6_level", {29'h0, fifo_level}, 3);
      do_reset();
      push_samp(8'h80, 1'b0);
      chk("t6_valid", {31'h0, samp_valid}, 1);
      chk("t6_data", {24'h0, samp_data}, {24'h0, conv(8'h80)});
      drain();
      chk("t6_sb_empty", exp_q.size(), 0);
      chk("end_coef_empty", coef_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
